// File: rtl/addsub4_checker.sv
// ============================================================================
// Module   : addsub4_checker
// Purpose  : Exhaustive 512-vector self-checker for an external addsub4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub4_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_m,
  output logic [3:0] dut_x,
  output logic [3:0] dut_y,
  input  logic [3:0] dut_s,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       first_fail_valid,
  output logic [8:0] first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [8:0] c_LAST_IDX    = 9'd511;

  state_t     r_state, w_state;
  logic [8:0] r_idx, w_idx;
  logic [3:0] r_cnt, w_cnt;
  logic [8:0] r_drive_vec, w_drive_vec;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_pass, w_pass;
  logic [9:0] r_err_count, w_err_count;
  logic       r_ffv, w_ffv;
  logic [8:0] r_ffvec, w_ffvec;

  logic [4:0] w_exp;
  logic       w_mismatch;

  // Subtraction as x + ~y + 1, so carry=1 means no borrow.
  assign w_exp = {1'b0, r_idx[7:4]}
               + {1'b0, r_idx[3:0] ^ {4{r_idx[8]}}}
               + {4'd0, r_idx[8]};
  assign w_mismatch = (dut_s != w_exp[3:0]) || (dut_cout != w_exp[4]);

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_drive_vec = r_drive_vec;
    w_busy      = r_busy;
    w_done      = r_done;
    w_pass      = r_pass;
    w_err_count = r_err_count;
    w_ffv       = r_ffv;
    w_ffvec     = r_ffvec;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state     = ST_DRIVE;
          w_idx       = 9'd0;
          w_cnt       = 4'd0;
          w_drive_vec = 9'd0;
          w_busy      = 1'b1;
          w_done      = 1'b0;
          w_pass      = 1'b0;
          w_err_count = 10'd0;
          w_ffv       = 1'b0;
          w_ffvec     = 9'd0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_SETTLE_LAST) begin
          w_state = ST_CHECK;
          w_cnt   = 4'd0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_err_count = r_err_count + 10'd1;
          if (!r_ffv) begin
            w_ffv   = 1'b1;
            w_ffvec = r_idx;
          end
        end
        if (r_idx == c_LAST_IDX) begin
          w_state     = ST_DONE;
          w_idx       = 9'd0;
          w_drive_vec = 9'd0;
          w_busy      = 1'b0;
          w_done      = 1'b1;
          w_pass      = (w_err_count == 10'd0);
        end else begin
          w_state     = ST_DRIVE;
          w_idx       = r_idx + 9'd1;
          w_drive_vec = r_idx + 9'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 9'd0;
      r_cnt       <= 4'd0;
      r_drive_vec <= 9'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 10'd0;
      r_ffv       <= 1'b0;
      r_ffvec     <= 9'd0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_cnt       <= w_cnt;
      r_drive_vec <= w_drive_vec;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_err_count <= w_err_count;
      r_ffv       <= w_ffv;
      r_ffvec     <= w_ffvec;
    end
  end

  assign dut_m            = r_drive_vec[8];
  assign dut_x            = r_drive_vec[7:4];
  assign dut_y            = r_drive_vec[3:0];
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

`default_nettype wire

// File: tb/tb_addsub4_checker.sv
// ============================================================================
// Module   : tb_addsub4_checker
// Purpose  : Bench for addsub4_checker with a fault-injectable addsub4 model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_addsub4_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start3;
  int   fault_mode;
  int   sel;

  logic       m1, m3, c1, c3;
  logic [3:0] x1, y1, s1, x3, y3, s3;
  logic       busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;
  logic [9:0] err1, err3;
  logic [8:0] ffvec1, ffvec3;

  addsub4_checker #(.SETTLE_CYCLES(1)) u_chk1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_m(m1), .dut_x(x1), .dut_y(y1), .dut_s(s1), .dut_cout(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  addsub4_checker #(.SETTLE_CYCLES(3)) u_chk3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .dut_m(m3), .dut_x(x3), .dut_y(y3), .dut_s(s3), .dut_cout(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
  );

  // Arithmetic meaning of add/subtract; carry in subtract mode = no borrow.
  function automatic logic [4:0] ideal(input logic m, input logic [3:0] x, input logic [3:0] y);
    int a, b;
    a = int'(x);
    b = int'(y);
    if (!m) return {(a + b) >= 16, 4'((a + b) % 16)};
    else    return {a >= b, 4'((a - b + 16) % 16)};
  endfunction

  // fm: 0 = correct, 1 = sum bit 0 stuck at 0, 2 = carry inverted
  function automatic logic [4:0] faulty(input logic m, input logic [3:0] x, input logic [3:0] y, input int fm);
    logic [4:0] r;
    r = ideal(m, x, y);
    if (fm == 1) r[0] = 1'b0;
    if (fm == 2) r[4] = ~r[4];
    return r;
  endfunction

  always_comb {c1, s1} = faulty(m1, x1, y1, fault_mode);
  always_comb {c3, s3} = faulty(m3, x3, y3, fault_mode);

  logic       o_busy, o_done, o_pass, o_ffv, o_m;
  logic [3:0] o_x, o_y;
  logic [9:0] o_err;
  logic [8:0] o_ffvec;
  always_comb begin
    o_busy  = (sel == 3) ? busy3  : busy1;
    o_done  = (sel == 3) ? done3  : done1;
    o_pass  = (sel == 3) ? pass3  : pass1;
    o_ffv   = (sel == 3) ? ffv3   : ffv1;
    o_err   = (sel == 3) ? err3   : err1;
    o_ffvec = (sel == 3) ? ffvec3 : ffvec1;
    o_m     = (sel == 3) ? m3     : m1;
    o_x     = (sel == 3) ? x3     : x1;
    o_y     = (sel == 3) ? y3     : y1;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 3) start3 = v;
    else        start1 = v;
  endtask

  function automatic logic [31:0] all_outs();
    return {o_busy, o_done, o_pass, o_ffv, o_err, o_ffvec, o_m, o_x, o_y};
  endfunction

  // Scoreboard: walk every vector, compare the attached model to ideal arithmetic.
  task automatic expect_for(input int fm, output int e_err, output logic e_ffv, output logic [8:0] e_vec);
    e_err = 0;
    e_ffv = 1'b0;
    e_vec = 9'd0;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      if (faulty(vv[8], vv[7:4], vv[3:0], fm) !== ideal(vv[8], vv[7:4], vv[3:0])) begin
        e_err++;
        if (!e_ffv) begin
          e_ffv = 1'b1;
          e_vec = vv;
        end
      end
    end
  endtask

  task automatic sweep(input int s, input int fm, input int repulse_at, input int abort_at);
    int         settle, exp_cycles, k, drv_err, e_err;
    logic       e_ffv;
    logic [8:0] e_vec, want;
    settle     = (s == 3) ? 3 : 1;
    exp_cycles = 512 * (settle + 1);
    sel        = s;
    fault_mode = fm;
    expect_for(fm, e_err, e_ffv, e_vec);

    @(negedge clk);
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    k = 0;
    check("accept_clears", {o_busy, o_done, o_pass, o_ffv, o_err}, {1'b1, 1'b0, 1'b0, 1'b0, 10'd0});

    drv_err = 0;
    while (!o_done && k <= exp_cycles + 8) begin
      want = 9'(k / (settle + 1));
      if ({o_m, o_x, o_y} !== want || o_busy !== 1'b1) drv_err++;
      if (k == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_all_zero", all_outs(), 32'd0);
        repeat (4) tick();
        check("abort_stays_idle", all_outs(), 32'd0);
        return;
      end
      if (k == repulse_at) set_start(s, 1'b1);
      tick();
      set_start(s, 1'b0);
      k++;
    end

    check("sweep_cycles", k, exp_cycles);
    check("drive_sequence_errs", drv_err, 0);
    check("done_busy", {o_done, o_busy}, 2'b10);
    check("err_count", {22'd0, o_err}, e_err);
    check("pass", o_pass, (e_err == 0));
    check("first_fail_valid", o_ffv, e_ffv);
    check("first_fail_vec", o_ffvec, e_vec);
    check("dut_inputs_idle", {o_m, o_x, o_y}, 9'd0);
    repeat (5) tick();
    check("done_hold", {o_done, o_pass, o_ffv, o_err, o_ffvec},
          {1'b1, e_err == 0, e_ffv, 10'(e_err), e_vec});
  endtask

  initial begin
    rst_n      = 1'b0;
    start1     = 1'b0;
    start3     = 1'b0;
    fault_mode = 0;
    sel        = 1;
    repeat (2) tick();
    check("reset_outs_s1", all_outs(), 32'd0);
    sel = 3;
    check("reset_outs_s3", all_outs(), 32'd0);
    // start asserted during reset must be ignored
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sel = 1;
    check("reset_beats_start", all_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    sweep(1, 0, int'($urandom_range(60, 900)), -1);
    sweep(1, 1, -1, -1);
    sweep(1, 2, int'($urandom_range(1, 1000)), -1);
    sweep(1, 0, -1, -1);
    sweep(1, 1, -1, int'($urandom_range(250, 350)));
    sweep(1, 0, -1, -1);
    sweep(3, 2, -1, -1);
    sweep(3, 0, int'($urandom_range(10, 2000)), -1);
    sweep(3, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
